if_stage: RTL
=============

IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, PC value loaded on reset.
REQ-002 Parameter MEM_WORDS, default 64, instruction memory depth in words.
REQ-003 clk  input  1  single clock, all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 imem_addr  output  32  byte address to instruction memory; equals PC.
REQ-006 imem_inst  input  32  instruction word returned combinationally for imem_addr.
REQ-007 stall  input  1  hazard unit hold request: freeze PC and IF/ID.
REQ-008 redirect  input  1  taken branch/jump/JR from later stage.
REQ-009 redirect_pc  input  32  redirect target byte address.
REQ-010 if_id_inst  output  32  latched instruction to decode.
REQ-011 if_id_pc4  output  32  latched PC+4 of that instruction.
REQ-012 if_id_valid  output  1  latched instruction is real, not bubble.
REQ-013 halted  output  1  fetch stopped on HALT instruction.
REQ-014 pc_oob  output  1  current PC outside MEM_WORDS range.

Function
REQ-015 States BOOT, RUN, HALT; reset enters BOOT.
REQ-016 BOOT lasts exactly one cycle (memory initialisation slot), produces bubble, PC held, then RUN.
REQ-017 RUN priority per cycle: redirect > stall > sequential.
REQ-018 Redirect: PC <= {redirect_pc[31:2],2'b00}; IF/ID <= bubble (inst 0, pc4 0, valid 0); ignores stall.
REQ-019 Stall without redirect: PC and all IF/ID outputs hold values.
REQ-020 Sequential: IF/ID <= {imem_inst, PC+4, 1}; PC <= PC+4, modulo 2^32 (wraps FFFF_FFFC -> 0000_0000).
REQ-021 pc_oob combinational, high when PC[31:2] >= MEM_WORDS; an oob fetch loads bubble, PC still advances.
REQ-022 Latency: instruction at PC appears on if_id_inst one cycle after PC presented, absent stall/redirect.
REQ-023 Bubble encoding 32'h0000_0000 (SLL R0,R0,0).

Reset
REQ-024 Reset: PC=RESET_PC, if_id_inst=0, if_id_pc4=0, if_id_valid=0, halted=0, state=BOOT.
REQ-025 Reset asserted mid-stall, mid-redirect or in HALT overrides all other inputs that cycle.

Configuration
REQ-026 Macro IF_HALT_DETECT_EN defined: instruction with opcode imem_inst[31:26]=6'b101101 latched normally into IF/ID, then state HALT.
REQ-027 In HALT: PC frozen, IF/ID loads bubble every cycle, halted=1; stall ignored.
REQ-028 Redirect while in HALT (halt fetched in branch shadow): apply redirect, halted=0, return RUN.
REQ-029 Halt fetched on a stall cycle takes effect only when the stall releases.
REQ-030 Macro undefined: opcode 101101 is an ordinary instruction, HALT state unreachable, halted tied 0.

Structure
REQ-031 Shared package holds state enum, opcode constant OP_HALT=6'b101101, BUBBLE_INST constant, word-align helper.
REQ-032 No sub-module; PC adder and IF/ID register inline; the instruction memory instantiates outside, at top level.

Verification
REQ-033 Reset then free-run, memory holding 8C010000, 34020004: IF/ID valid=0 for reset+BOOT, then 8C010000/pc4=4, then 34020004/pc4=8.
REQ-034 stall high 3 cycles at PC=0x10: PC stays 0x10, IF/ID unchanged 3 cycles, resumes with inst at 0x10.
REQ-035 redirect=1, redirect_pc=0x0000_0066 together with stall=1: next PC=0x64, IF/ID bubble valid=0, then inst at 0x64.
REQ-036 Macro defined, B4221820 at 0x84: IF/ID shows B4221820 valid=1, then halted=1, PC=0x88 frozen, bubbles; redirect to 0x20 -> halted=0, fetch resumes at 0x20.
REQ-037 PC reaches 0x100 with MEM_WORDS=64: pc_oob=1, bubble latched; RESET_PC=FFFF_FFFC: PC wraps to 0.
REQ-038 Reset asserted in HALT and during stall: all outputs return to REQ-024 values next cycle.

Source files
------------

// File: rtl/if_stage_pkg.sv
// Shared types and constants for the instruction-fetch stage: FSM state
// encoding, the HALT opcode, the bubble encoding and a word-align helper.
package if_stage_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } state_e;

  localparam logic [5:0] OP_HALT     = 6'b101101;
  localparam word_t      BUBBLE_INST = 32'h0000_0000;

  function automatic word_t word_align(input word_t addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/if_stage_if.sv
// Fetch-stage bus: instruction memory port, hazard/redirect controls and the
// IF/ID register outputs. The fetch stage uses master, its environment slave.
interface if_stage_if;
  import if_stage_pkg::*;

  word_t imem_addr;
  word_t imem_inst;
  logic  stall;
  logic  redirect;
  word_t redirect_pc;
  word_t if_id_inst;
  word_t if_id_pc4;
  logic  if_id_valid;
  logic  halted;
  logic  pc_oob;

  modport master (
    output imem_addr, if_id_inst, if_id_pc4, if_id_valid, halted, pc_oob,
    input  imem_inst, stall, redirect, redirect_pc
  );

  modport slave (
    input  imem_addr, if_id_inst, if_id_pc4, if_id_valid, halted, pc_oob,
    output imem_inst, stall, redirect, redirect_pc
  );

endinterface

// File: rtl/if_stage.sv
// Instruction-fetch stage: PC register, PC+4 adder and IF/ID register.
// Optional HALT-opcode detection is enabled by defining IF_HALT_DETECT_EN.
//
// state | meaning
// BOOT  | one-cycle memory init slot after reset, bubble, PC held
// RUN   | normal fetch: redirect > stall > sequential
// HALT  | HALT fetched; PC frozen, bubbles until a redirect arrives
module if_stage
  import if_stage_pkg::*;
#(
  parameter word_t RESET_PC  = 32'h0000_0000,
  parameter int    MEM_WORDS = 64
) (
  input logic       clk,
  input logic       reset,
  if_stage_if.master bus
);

  state_e state_q, next_state;
  word_t  pc_q, pc_d, pc_plus4;
  word_t  inst_q, inst_d, pc4_q, pc4_d;
  logic   valid_q, valid_d;
  logic   oob;

  assign pc_plus4 = pc_q + 32'd4;
  assign oob      = {2'b00, pc_q[31:2]} >= 32'(MEM_WORDS);

  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_BOOT;
    else       state_q <= next_state;
  end

  always_comb begin
    next_state = state_q;
    case (state_q)
      ST_BOOT: next_state = ST_RUN;
      ST_RUN: begin
`ifdef IF_HALT_DETECT_EN
        if (!bus.redirect && !bus.stall && !oob && bus.imem_inst[31:26] == OP_HALT)
          next_state = ST_HALT;
`endif
      end
      ST_HALT: if (bus.redirect) next_state = ST_RUN;
      default: next_state = ST_BOOT;
    endcase
  end

  always_comb begin
    pc_d    = pc_q;
    inst_d  = inst_q;
    pc4_d   = pc4_q;
    valid_d = valid_q;
    case (state_q)
      ST_RUN: begin
        if (bus.redirect) begin
          pc_d    = word_align(bus.redirect_pc);
          inst_d  = BUBBLE_INST;
          pc4_d   = '0;
          valid_d = 1'b0;
        end else if (!bus.stall) begin
          // out-of-range fetches still advance the PC but deliver a bubble
          pc_d    = pc_plus4;
          inst_d  = oob ? BUBBLE_INST : bus.imem_inst;
          pc4_d   = oob ? '0 : pc_plus4;
          valid_d = !oob;
        end
      end
      ST_HALT: begin
        if (bus.redirect) pc_d = word_align(bus.redirect_pc);
        inst_d  = BUBBLE_INST;
        pc4_d   = '0;
        valid_d = 1'b0;
      end
      default: begin
        inst_d  = BUBBLE_INST;
        pc4_d   = '0;
        valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q    <= RESET_PC;
      inst_q  <= BUBBLE_INST;
      pc4_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      inst_q  <= inst_d;
      pc4_q   <= pc4_d;
      valid_q <= valid_d;
    end
  end

  assign bus.imem_addr   = pc_q;
  assign bus.if_id_inst  = inst_q;
  assign bus.if_id_pc4   = pc4_q;
  assign bus.if_id_valid = valid_q;
  assign bus.pc_oob      = oob;
`ifdef IF_HALT_DETECT_EN
  assign bus.halted      = (state_q == ST_HALT);
`else
  assign bus.halted      = 1'b0;
`endif

endmodule
